// File: rtl/instr_mem_pkg.sv
// rtl/instr_mem_pkg.sv - shared constants and state encoding for the instruction ROM loader
package instr_mem_pkg;

  localparam int ROM_DEPTH = 16;
  localparam int INSTR_W   = 16;
  localparam int ADDR_W    = 4;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_HI = 2'd1,
    LOAD_LO = 2'd2
  } state_t;

endpackage

// File: rtl/instr_mem.sv
// rtl/instr_mem.sv - byte-loaded instruction memory with registered fetch port
// Fetch returns NOP while a program load is in flight.
module instr_mem
  import instr_mem_pkg::INSTR_W, instr_mem_pkg::ADDR_W, instr_mem_pkg::state_t,
         instr_mem_pkg::IDLE, instr_mem_pkg::LOAD_HI, instr_mem_pkg::LOAD_LO;
#(
  parameter int                 ROM_DEPTH = instr_mem_pkg::ROM_DEPTH,
  parameter logic [INSTR_W-1:0] NOP_INSTR = instr_mem_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  fetch_addr,
  output logic [INSTR_W-1:0] instruction,
  input  logic               load_start,
  input  logic               load_valid,
  input  logic [7:0]         load_data,
  output logic               load_ready,
  output logic               load_done,
  output logic               busy
);

  localparam int            AW        = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
  localparam logic [AW-1:0] LAST_WORD = AW'(ROM_DEPTH - 1);

  state_t             state;
  logic [AW-1:0]      wptr;
  logic [7:0]         hi_byte;
  logic [INSTR_W-1:0] mem [ROM_DEPTH];

  logic [AW-1:0] rd_idx;
  logic          byte_accept;

  assign rd_idx      = AW'(int'(fetch_addr) % ROM_DEPTH);
  assign byte_accept = load_valid & load_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wptr        <= '0;
      hi_byte     <= '0;
      instruction <= NOP_INSTR;
      load_done   <= 1'b0;
      load_ready  <= 1'b0;
      busy        <= 1'b0;
      for (int i = 0; i < ROM_DEPTH; i++) begin
        mem[i] <= NOP_INSTR;
      end
    end else begin
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          // The start edge already outputs NOP so busy and NOP rise together.
          if (load_start) begin
            state       <= LOAD_HI;
            wptr        <= '0;
            load_ready  <= 1'b1;
            busy        <= 1'b1;
            instruction <= NOP_INSTR;
          end else begin
            instruction <= mem[rd_idx];
          end
        end
        LOAD_HI: begin
          instruction <= NOP_INSTR;
          if (byte_accept) begin
            hi_byte <= load_data;
            state   <= LOAD_LO;
          end
        end
        LOAD_LO: begin
          instruction <= NOP_INSTR;
          if (byte_accept) begin
            mem[wptr] <= {hi_byte, load_data};
            if (wptr == LAST_WORD) begin
              state      <= IDLE;
              load_ready <= 1'b0;
              busy       <= 1'b0;
              load_done  <= 1'b1;
            end else begin
              wptr  <= wptr + 1'b1;
              state <= LOAD_HI;
            end
          end
        end
        default: begin
          state       <= IDLE;
          load_ready  <= 1'b0;
          busy        <= 1'b0;
          instruction <= NOP_INSTR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem.sv
// tb/tb_instr_mem.sv - scoreboard bench for instr_mem
module tb_instr_mem;

  localparam int K_INSTR = 0;
  localparam int K_BUSY  = 1;
  localparam int K_READY = 2;

  typedef struct {
    int          due;
    int          kind;
    logic [15:0] exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  fetch_addr;
  logic [15:0] instruction;
  logic        load_start;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_ready;
  logic        load_done;
  logic        busy;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  int   done_q[$];

  instr_mem dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_addr (fetch_addr),
    .instruction(instruction),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_done  (load_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares scheduled expectations and every load_done pulse.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t        e;
      logic [15:0] act;
      string       nm;
      e = sb.pop_front();
      case (e.kind)
        K_INSTR: begin act = instruction;       nm = "instruction"; end
        K_BUSY:  begin act = {15'd0, busy};      nm = "busy";        end
        default: begin act = {15'd0, load_ready}; nm = "load_ready";  end
      endcase
      checks++;
      if (e.due != cyc || act !== e.exp) begin
        failures++;
        $display("FAIL %s cyc=%0d due=%0d actual=%h expected=%h", nm, cyc, e.due, act, e.exp);
      end
    end
    if (load_done === 1'b1) begin
      checks++;
      if (done_q.size() > 0 && done_q[0] == cyc) begin
        void'(done_q.pop_front());
      end else begin
        failures++;
        $display("FAIL load_done unexpected pulse cyc=%0d", cyc);
      end
    end
    if (done_q.size() > 0 && done_q[0] < cyc) begin
      checks++;
      failures++;
      $display("FAIL load_done missing at cyc=%0d actual=0 expected=1", done_q[0]);
      void'(done_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input int kind, input logic [15:0] exp, input int delay);
    exp_t e;
    e.due  = cyc + delay;
    e.kind = kind;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  // Fetch every address; image_base==0 means an all-NOP image.
  task automatic sweep(input logic [15:0] image_base);
    for (int a = 0; a < 16; a++) begin
      fetch_addr = 4'(a);
      expect_val(K_INSTR, (image_base == 16'h0) ? 16'h0 : image_base + 16'(a), 1);
      tick();
    end
  endtask

  // Program word n = 16'h1000 + n, high byte first.
  task automatic load_prog(input int n_bytes, input bit gapped, input bit repulse);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    expect_val(K_BUSY, 16'd1, 0);
    expect_val(K_READY, 16'd1, 0);
    expect_val(K_INSTR, 16'h0000, 0);
    for (int k = 0; k < n_bytes; k++) begin
      if (gapped) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          load_valid = 1'b0;
          load_data  = 8'hEE;
          expect_val(K_READY, 16'd1, 1);
          tick();
        end
      end
      load_valid = 1'b1;
      load_data  = (k % 2 == 0) ? 8'h10 : 8'(k / 2);
      if (repulse && k == 6) load_start = 1'b1;
      if (k == 31) done_q.push_back(cyc + 1);
      expect_val(K_INSTR, 16'h0000, 1);
      tick();
      load_valid = 1'b0;
      load_start = 1'b0;
    end
    if (n_bytes == 32) begin
      expect_val(K_BUSY, 16'd0, 0);
      expect_val(K_READY, 16'd0, 0);
      expect_val(K_INSTR, 16'h1000 + 16'(fetch_addr), 1);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    fetch_addr = 4'h0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'h00;
    repeat (3) tick();
    expect_val(K_BUSY, 16'd0, 0);
    expect_val(K_READY, 16'd0, 0);
    expect_val(K_INSTR, 16'h0000, 0);
    rst = 1'b1;
    tick();

    // Empty memory after reset.
    expect_val(K_BUSY, 16'd0, 1);
    expect_val(K_READY, 16'd0, 1);
    sweep(16'h0000);

    // Continuous load, fetch parked on the last address across the exit.
    fetch_addr = 4'hF;
    tick();
    load_prog(32, 1'b0, 1'b0);
    sweep(16'h1000);

    // Reset mid-load after byte 13 clears everything already written.
    fetch_addr = 4'h3;
    tick();
    load_prog(13, 1'b0, 1'b0);
    rst = 1'b0;
    expect_val(K_BUSY, 16'd0, 0);
    expect_val(K_READY, 16'd0, 0);
    expect_val(K_INSTR, 16'h0000, 0);
    tick();
    rst = 1'b1;
    tick();
    sweep(16'h0000);

    // Gapped load with a stray load_start at byte 7.
    fetch_addr = 4'hF;
    tick();
    load_prog(32, 1'b1, 1'b1);
    sweep(16'h1000);

    // Bytes offered while idle must be dropped.
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = 8'hFF;
      expect_val(K_READY, 16'd0, 1);
      expect_val(K_BUSY, 16'd0, 1);
      tick();
    end
    load_valid = 1'b0;
    sweep(16'h1000);

    repeat (3) tick();
    checks++;
    if (done_q.size() != 0 || sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending_done=%0d pending_sb=%0d expected=0", done_q.size(), sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_mem.md
INSTR_MEM -- requirements
Module: instr_mem

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset (clk, rst); all other timing is relative to the rising edge of clk.
REQ-002 Parameter ROM_DEPTH, default 16, SHALL set the number of 16-bit instruction words.
REQ-003 Parameter NOP_INSTR, default 16'h0000, SHALL be the word driven while fetch is unavailable (opcode 0 decodes as NOP).
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  asynchronous reset, active-low.
REQ-006 fetch_addr  input  4  instruction address from the processor.
REQ-007 instruction  output  16  registered fetch data to the processor.
REQ-008 load_start  input  1  single-cycle pulse that begins a full program load.
REQ-009 load_valid  input  1  a load byte is present on load_data.
REQ-010 load_data  input  8  load byte; high byte of each word first, then low byte.
REQ-011 load_ready  output  1  the block accepts a byte this cycle.
REQ-012 load_done  output  1  one-cycle pulse after the final word is written.
REQ-013 busy  output  1  load in progress; fetch is unavailable.

Function
REQ-014 States SHALL be IDLE, LOAD_HI and LOAD_LO.
REQ-015 IDLE -> LOAD_HI on load_start; word pointer wptr is cleared to 0.
REQ-016 LOAD_HI -> LOAD_LO on byte accept (load_valid & load_ready); the byte is held in a hi_byte register.
REQ-017 LOAD_LO on byte accept SHALL write mem[wptr] <= {hi_byte, load_data}, then:
- if wptr != ROM_DEPTH-1: increment wptr and go to LOAD_HI;
- if wptr == ROM_DEPTH-1: go to IDLE and assert load_done on the next cycle.
REQ-018 A byte accept SHALL occur only when load_valid and load_ready are both 1. Without load_valid, the state, wptr and hi_byte SHALL hold indefinitely (no timeout).
REQ-019 load_ready SHALL be 1 in LOAD_HI and LOAD_LO, and 0 in IDLE; it is a registered state decode, not combinational on load_valid.
REQ-020 busy SHALL be 1 exactly when state is not IDLE.
REQ-021 load_start while busy SHALL be ignored; the load continues with no restart.
REQ-022 load_valid in IDLE SHALL be ignored, and the memory SHALL be unchanged.
REQ-023 In IDLE, instruction SHALL update each clock edge to mem[fetch_addr], giving one-cycle read latency.
REQ-024 While busy, instruction SHALL be NOP_INSTR.
REQ-025 On the edge leaving LOAD_LO for IDLE, instruction SHALL still be NOP_INSTR; the first new fetch data appears on the following edge.
REQ-026 fetch_addr values at or above ROM_DEPTH SHALL wrap modulo ROM_DEPTH.
REQ-027 wptr SHALL be clog2(ROM_DEPTH) bits wide, and the final-word compare SHALL use ROM_DEPTH-1 exactly; there is no write past the array.
REQ-028 load_done SHALL be high for exactly one cycle per completed load and never otherwise.

Reset
REQ-029 Asserting rst SHALL immediately force:
- state = IDLE, wptr = 0, hi_byte = 0;
- instruction = NOP_INSTR, load_done = 0, load_ready = 0, busy = 0;
- every mem word = NOP_INSTR.
REQ-030 rst asserted mid-load SHALL abort the load with no load_done pulse; words already written are cleared to NOP_INSTR.
REQ-031 rst deassertion SHALL be synchronised externally; the block requires no more than one idle cycle after release before load_start is honoured.

Structure
REQ-032 Shared package instr_mem_pkg SHALL hold ROM_DEPTH, INSTR_W=16, ADDR_W=4, NOP_INSTR and the state enum (IDLE, LOAD_HI, LOAD_LO).
REQ-033 The block SHALL be a single module with no sub-modules; the memory is a register array, inferred without a vendor macro.

Verification
REQ-034 Reset, no load; fetch_addr swept 0..15 -> instruction = 16'h0000 every cycle; busy = 0; load_ready = 0.
REQ-035 Full load, one byte per cycle (word n = 16'h1000 + n); sweep fetch 0..15 -> instruction[n] = 16'h1000 + n one cycle after each address; load_done high exactly once, one cycle after byte 32.
REQ-036 Load with load_valid toggled 1,0,0,1 per cycle, random gaps -> identical memory image as REQ-035; only bytes with load_valid & load_ready are consumed.
REQ-037 load_start re-pulsed at byte 7; load_valid in IDLE with data 8'hFF -> no restart, no extra write; final image unchanged from REQ-035.
REQ-038 rst asserted after byte 13 -> busy = 0 and instruction = 16'h0000 immediately; no load_done pulse; subsequent full load succeeds.
REQ-039 fetch_addr held at 4'hF across the load end -> NOP_INSTR on the exit edge; mem[15] on the next edge.
